// File: rtl/calendar_pkg.sv
// Shared calendar constants and the month-length one-hot decode used by the date register.
// Day/month widths, month bounds and the 28/29/30/31 length encodings live here.
package calendar_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [MONTH_W-1:0] MONTH_JAN = 4'd1;
  localparam logic [MONTH_W-1:0] MONTH_DEC = 4'd12;

  localparam logic [DAY_W-1:0] DAY_MIN = 5'd1;
  localparam logic [DAY_W-1:0] DAY_MAX = 5'd31;

  localparam logic [DAY_W-1:0] LEN_28 = 5'd28;
  localparam logic [DAY_W-1:0] LEN_29 = 5'd29;
  localparam logic [DAY_W-1:0] LEN_30 = 5'd30;
  localparam logic [DAY_W-1:0] LEN_31 = 5'd31;

  typedef struct packed {
    logic             valid;
    logic [DAY_W-1:0] days;
  } month_len_t;

  // Exactly one of the four inputs must be high; anything else is flagged invalid.
  function automatic month_len_t decode_len(input logic m28, input logic m29,
                                            input logic m30, input logic m31);
    month_len_t r;
    r.valid = 1'b1;
    r.days  = DAY_MAX;
    case ({m28, m29, m30, m31})
      4'b1000: r.days = LEN_28;
      4'b0100: r.days = LEN_29;
      4'b0010: r.days = LEN_30;
      4'b0001: r.days = LEN_31;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/year_counter.sv
// Year offset register (years since 2000) with load, wrap-to-zero increment and leap flag.
// Leap is simply year[1:0]==0, which is correct for the 2000..2099 window.
module year_counter #(
  parameter int YEAR_W     = 7,
  parameter int YEAR_MAX   = 99,
  parameter int YEAR_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [YEAR_W-1:0] load_value,
  output logic [YEAR_W-1:0] year,
  output logic              leap
);

  logic [YEAR_W-1:0] year_reg;
  logic [YEAR_W-1:0] year_next;

  always_comb begin
    year_next = year_reg;
    if (load) begin
      year_next = load_value;
    end else if (inc) begin
      year_next = (year_reg == YEAR_W'(YEAR_MAX)) ? '0 : year_reg + YEAR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      year_reg <= YEAR_W'(YEAR_RESET);
    end else begin
      year_reg <= year_next;
    end
  end

  assign year = year_reg;
  assign leap = (year_reg[1:0] == 2'b00);

endmodule

// File: rtl/date_counter.sv
// Day/month/year calendar register advancing one day per tick, with load validation.
// Month length arrives combinationally from an external decoder driven by month_out/leap_out.
module date_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_W     = 7,
  parameter int YEAR_MAX   = 99,
  parameter int YEAR_RESET = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               load,
  input  logic [DAY_W-1:0]   load_day,
  input  logic [MONTH_W-1:0] load_month,
  input  logic [YEAR_W-1:0]  load_year,
  input  logic               m28,
  input  logic               m29,
  input  logic               m30,
  input  logic               m31,
  output logic [DAY_W-1:0]   day_out,
  output logic [MONTH_W-1:0] month_out,
  output logic               leap_out,
  output logic [YEAR_W-1:0]  year_out,
  output logic               month_wrap,
  output logic               year_wrap,
  output logic               load_err,
  output logic               len_err
);

  logic [DAY_W-1:0]   day_reg,   day_next;
  logic [MONTH_W-1:0] month_reg, month_next;
  logic month_wrap_reg, month_wrap_next;
  logic year_wrap_reg,  year_wrap_next;
  logic load_err_reg,   load_err_next;
  logic len_err_reg,    len_err_next;

  month_len_t len_info;
  logic       load_ok;
  logic       at_month_end;
  logic       year_inc;
  logic       year_load;

  always_comb begin
    len_info     = decode_len(m28, m29, m30, m31);
    // Day range is not checked against month length; over-length days roll on the next tick.
    load_ok      = (load_month >= MONTH_JAN) && (load_month <= MONTH_DEC) &&
                   (load_day >= DAY_MIN) && (load_day <= DAY_MAX) &&
                   (load_year <= YEAR_W'(YEAR_MAX));
    at_month_end = (day_reg >= len_info.days);

    day_next        = day_reg;
    month_next      = month_reg;
    month_wrap_next = 1'b0;
    year_wrap_next  = 1'b0;
    load_err_next   = 1'b0;
    len_err_next    = len_err_reg;
    year_inc        = 1'b0;
    year_load       = 1'b0;

    if (load) begin
      if (load_ok) begin
        day_next     = load_day;
        month_next   = load_month;
        year_load    = 1'b1;
        len_err_next = 1'b0;
      end else begin
        load_err_next = 1'b1;
      end
    end else if (tick) begin
      if (!len_info.valid) begin
        len_err_next = 1'b1;
      end else if (!at_month_end) begin
        day_next = day_reg + DAY_W'(1);
      end else begin
        day_next        = DAY_MIN;
        month_wrap_next = 1'b1;
        if (month_reg < MONTH_DEC) begin
          month_next = month_reg + MONTH_W'(1);
        end else begin
          month_next     = MONTH_JAN;
          year_wrap_next = 1'b1;
          year_inc       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      day_reg        <= DAY_MIN;
      month_reg      <= MONTH_JAN;
      month_wrap_reg <= 1'b0;
      year_wrap_reg  <= 1'b0;
      load_err_reg   <= 1'b0;
      len_err_reg    <= 1'b0;
    end else begin
      day_reg        <= day_next;
      month_reg      <= month_next;
      month_wrap_reg <= month_wrap_next;
      year_wrap_reg  <= year_wrap_next;
      load_err_reg   <= load_err_next;
      len_err_reg    <= len_err_next;
    end
  end

  year_counter #(
    .YEAR_W     (YEAR_W),
    .YEAR_MAX   (YEAR_MAX),
    .YEAR_RESET (YEAR_RESET)
  ) u_year (
    .clk        (clk),
    .rst        (rst),
    .inc        (year_inc),
    .load       (year_load),
    .load_value (load_year),
    .year       (year_out),
    .leap       (leap_out)
  );

  assign day_out    = day_reg;
  assign month_out  = month_reg;
  assign month_wrap = month_wrap_reg;
  assign year_wrap  = year_wrap_reg;
  assign load_err   = load_err_reg;
  assign len_err    = len_err_reg;

endmodule
